axi_to_axi_lite_bridge: RTL and testbench
=========================================

Name: axi_to_axi_lite_bridge

Overview:
- Converts an AXI4 (full) slave port into an AXI-lite master port by splitting each burst into single-beat AXI-lite transactions.
- Sits directly upstream of the AXI-lite BRAM controller, so AXI4 bursting masters (CPU caches, DMA) can reach BRAM through it.
- Read and write paths are independent; each holds one burst in flight.

Parameters:
- ADDR_WIDTH, 48, address width of both ports.
- DATA_WIDTH, 64, data width of both ports; no width conversion.
- ID_WIDTH, 8, AXI4 ID width; the ID is held per burst and returned on R/B.

Ports:
- clk  input  1  clock; drives both interfaces.
- rstn  input  1  asynchronous active-low reset.
- master  axi_channel.slave  -  AXI4 port from the upstream master (AW/W/B/AR/R with id, len, size, burst, last).
- slave  axi_lite_channel.master  -  AXI-lite port to the downstream slave; every AXI-lite request carries prot copied from the burst.

Behaviour:
- Reset values:
  - all valid outputs 0 (master.aw_ready, w_ready, ar_ready, b_valid, r_valid; slave.aw_valid, w_valid, ar_valid);
  - beat and outstanding counters 0;
  - both FSMs in IDLE.
- Reset mid-burst: all in-flight state is discarded, with no completion response; the downstream slave is reset by the same rstn.
- Address generation per beat, with beat size B = 1<<size:
  - FIXED: address unchanged.
  - INCR: address += B; carries propagate across the full ADDR_WIDTH.
  - WRAP: address += B, wrapping within an aligned window of (len+1)*B bytes; len must be 1, 3, 7 or 15, otherwise behaviour is undefined.
  - Reserved burst type (2'b11): handled as INCR.
  - Misaligned start address: passed through unaligned on beat 0; later beats are aligned to size.
  - 4KB crossing is not checked.
- Read FSM, states IDLE -> ISSUE -> DRAIN -> IDLE:
  - IDLE: master.ar_ready=1. On handshake, latch id/addr/len/size/burst/prot, set issue_cnt=len+1, set ret_cnt=len+1, go ISSUE.
  - ISSUE: slave.ar_valid=1 with the current address. On each slave AR handshake, advance the address and decrement issue_cnt. After the last handshake go DRAIN, or IDLE if all R beats have already returned.
  - R path runs in every state: slave.r_* is forwarded combinationally to master.r_*, with r_id = latched id and r_last = (ret_cnt==1); slave.r_ready = master.r_ready. Each handshake decrements ret_cnt. When ret_cnt reaches 0 and issue_cnt is 0, return to IDLE.
  - A new AR is accepted only in IDLE, i.e. one burst in flight; back-to-back bursts allow one idle cycle.
  - Throughput: one beat per cycle when downstream sustains it.
- Write FSM, states IDLE -> ISSUE -> RESP -> IDLE:
  - IDLE: master.aw_ready=1. On handshake, latch fields, set aw_cnt=len+1, set b_cnt=len+1, set err=OKAY, go ISSUE.
  - ISSUE, AW channel: slave.aw_valid while aw_cnt>0; each handshake advances the address and decrements aw_cnt.
  - ISSUE, W channel: master.w_* is forwarded to slave.w_* combinationally and w_last is dropped. w_ready/w_valid are gated so no more W beats are forwarded than len+1.
  - W gating limit: at most len+1 W beats are forwarded. W may precede or follow AW; the AXI-lite slave buffers independently.
  - B collection runs in ISSUE and RESP: slave.b_ready=1, with no upstream backpressure until the final beat. Each B handshake decrements b_cnt. The first SLVERR/DECERR seen is kept in err; later responses never overwrite an error.
  - When b_cnt==0: master.b_valid=1 with b_id = latched id and b_resp = err. Hold until master.b_ready, then go IDLE.
  - A master W beat with w_last mismatching the beat count is accepted without check.
- Responses never combine across bursts. EXOKAY is never produced; AXI4 lock is ignored.
- No combinational path from master.b_ready to master.aw_ready within one cycle.

Test Plan:
- Read INCR: AR addr=0x100, len=3, size=3, id=5 -> slave sees AR 0x100, 0x108, 0x110, 0x118. Master receives 4 R beats with id=5, data passed through, r_last only on the 4th.
- Write WRAP: AW addr=0x118, len=3, size=3, 4 W beats -> slave AW 0x118, 0x100, 0x108, 0x110. Exactly one master B (id preserved, OKAY) after the 4th slave B.
- Write error merge: len=2, slave B = OKAY, SLVERR, DECERR -> single master B with resp=SLVERR.
- Backpressure: master.r_ready low for 5 cycles mid-burst -> no R beat lost or duplicated, and slave.r_ready tracks master.r_ready. W before AW: 2 W beats presented 3 cycles before AW len=1 -> both forwarded, B correct.
- FIXED read len=7 at 0x40 -> 8 slave ARs all 0x40. Reset asserted after the 2nd of 8 beats -> all valids 0 asynchronously, FSMs IDLE, and a new burst after reset completes normally.
- Back-to-back: two AR bursts (len=0, id=1; len=1, id=2) -> R ids 1, 2, 2 in order, with r_last on beats 1 and 3.

Source files
------------

// File: rtl/axi_to_axi_lite_bridge.sv
// AXI4 to AXI-lite bridge: splits each AXI4 burst into single-beat AXI-lite
// transactions. Read and write paths are independent, one burst in flight each.
module axi_to_axi_lite_bridge #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  // AXI4 port from the upstream master
  input  logic [ID_WIDTH-1:0]       master_aw_id,
  input  logic [ADDR_WIDTH-1:0]     master_aw_addr,
  input  logic [7:0]                master_aw_len,
  input  logic [2:0]                master_aw_size,
  input  logic [1:0]                master_aw_burst,
  input  logic [2:0]                master_aw_prot,
  input  logic                      master_aw_valid,
  output logic                      master_aw_ready,
  input  logic [DATA_WIDTH-1:0]     master_w_data,
  input  logic [DATA_WIDTH/8-1:0]   master_w_strb,
  input  logic                      master_w_last,
  input  logic                      master_w_valid,
  output logic                      master_w_ready,
  output logic [ID_WIDTH-1:0]       master_b_id,
  output logic [1:0]                master_b_resp,
  output logic                      master_b_valid,
  input  logic                      master_b_ready,
  input  logic [ID_WIDTH-1:0]       master_ar_id,
  input  logic [ADDR_WIDTH-1:0]     master_ar_addr,
  input  logic [7:0]                master_ar_len,
  input  logic [2:0]                master_ar_size,
  input  logic [1:0]                master_ar_burst,
  input  logic [2:0]                master_ar_prot,
  input  logic                      master_ar_valid,
  output logic                      master_ar_ready,
  output logic [ID_WIDTH-1:0]       master_r_id,
  output logic [DATA_WIDTH-1:0]     master_r_data,
  output logic [1:0]                master_r_resp,
  output logic                      master_r_last,
  output logic                      master_r_valid,
  input  logic                      master_r_ready,
  // AXI-lite port to the downstream slave
  output logic [ADDR_WIDTH-1:0]     slave_aw_addr,
  output logic [2:0]                slave_aw_prot,
  output logic                      slave_aw_valid,
  input  logic                      slave_aw_ready,
  output logic [DATA_WIDTH-1:0]     slave_w_data,
  output logic [DATA_WIDTH/8-1:0]   slave_w_strb,
  output logic                      slave_w_valid,
  input  logic                      slave_w_ready,
  input  logic [1:0]                slave_b_resp,
  input  logic                      slave_b_valid,
  output logic                      slave_b_ready,
  output logic [ADDR_WIDTH-1:0]     slave_ar_addr,
  output logic [2:0]                slave_ar_prot,
  output logic                      slave_ar_valid,
  input  logic                      slave_ar_ready,
  input  logic [DATA_WIDTH-1:0]     slave_r_data,
  input  logic [1:0]                slave_r_resp,
  input  logic                      slave_r_valid,
  output logic                      slave_r_ready
);

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_DRAIN} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ISSUE, WR_RESP} wr_state_t;

  // Next beat address; misaligned starts snap to size alignment after beat 0.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] beat_bytes;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] len_ext;
    beat_bytes = ONE << size;
    aligned    = addr & ~(beat_bytes - ONE);
    incr       = aligned + beat_bytes;
    len_ext    = {{(ADDR_WIDTH-8){1'b0}}, len};
    wrap_mask  = ((len_ext + ONE) << size) - ONE;
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default: next_addr = incr;
    endcase
  endfunction

  // Register state
  rd_state_t             rd_state_q, rd_state_d;
  wr_state_t             wr_state_q, wr_state_d;
  logic                  run_q, run_d;
  logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]            ar_len_q, ar_len_d;
  logic [2:0]            ar_size_q, ar_size_d;
  logic [1:0]            ar_burst_q, ar_burst_d;
  logic [2:0]            ar_prot_q, ar_prot_d;
  logic [8:0]            issue_cnt_q, issue_cnt_d;
  logic [8:0]            ret_cnt_q, ret_cnt_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]            aw_len_q, aw_len_d;
  logic [2:0]            aw_size_q, aw_size_d;
  logic [1:0]            aw_burst_q, aw_burst_d;
  logic [2:0]            aw_prot_q, aw_prot_d;
  logic [8:0]            aw_cnt_q, aw_cnt_d;
  logic [8:0]            w_cnt_q, w_cnt_d;
  logic [8:0]            b_cnt_q, b_cnt_d;
  logic [1:0]            err_q, err_d;
  logic                  w_open;
  logic                  unused_w_last;

  assign unused_w_last = master_w_last;
  assign run_d = 1'b1;

  // R path is a straight pass-through; valid is masked when nothing is owed.
  assign master_r_valid = slave_r_valid && (ret_cnt_q != 9'd0);
  assign master_r_data  = slave_r_data;
  assign master_r_resp  = slave_r_resp;
  assign master_r_id    = ar_id_q;
  assign master_r_last  = (ret_cnt_q == 9'd1);
  assign slave_r_ready  = master_r_ready;
  assign slave_ar_addr  = ar_addr_q;
  assign slave_ar_prot  = ar_prot_q;

  // W path is forwarded only while beats of the current burst remain.
  assign w_open         = (wr_state_q == WR_ISSUE) && (w_cnt_q != 9'd0);
  assign slave_w_valid  = w_open && master_w_valid;
  assign master_w_ready = w_open && slave_w_ready;
  assign slave_w_data   = master_w_data;
  assign slave_w_strb   = master_w_strb;
  assign slave_aw_addr  = aw_addr_q;
  assign slave_aw_prot  = aw_prot_q;
  assign master_b_id    = aw_id_q;
  assign master_b_resp  = err_q;

  // Read FSM: accept one burst, issue its single-beat ARs, count returning R beats.
  always_comb begin
    rd_state_d      = rd_state_q;
    ar_id_d         = ar_id_q;
    ar_addr_d       = ar_addr_q;
    ar_len_d        = ar_len_q;
    ar_size_d       = ar_size_q;
    ar_burst_d      = ar_burst_q;
    ar_prot_d       = ar_prot_q;
    issue_cnt_d     = issue_cnt_q;
    ret_cnt_d       = ret_cnt_q;
    master_ar_ready = 1'b0;
    slave_ar_valid  = 1'b0;
    if (master_r_valid && master_r_ready) begin
      ret_cnt_d = ret_cnt_q - 9'd1;
    end
    case (rd_state_q)
      RD_IDLE: begin
        master_ar_ready = run_q;
        if (run_q && master_ar_valid) begin
          ar_id_d     = master_ar_id;
          ar_addr_d   = master_ar_addr;
          ar_len_d    = master_ar_len;
          ar_size_d   = master_ar_size;
          ar_burst_d  = master_ar_burst;
          ar_prot_d   = master_ar_prot;
          issue_cnt_d = {1'b0, master_ar_len} + 9'd1;
          ret_cnt_d   = {1'b0, master_ar_len} + 9'd1;
          rd_state_d  = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        slave_ar_valid = 1'b1;
        if (slave_ar_ready) begin
          ar_addr_d   = next_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);
          issue_cnt_d = issue_cnt_q - 9'd1;
          if (issue_cnt_q == 9'd1) begin
            rd_state_d = (ret_cnt_d == 9'd0) ? RD_IDLE : RD_DRAIN;
          end
        end
      end
      RD_DRAIN: begin
        if (ret_cnt_d == 9'd0) begin
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Write FSM: issue single-beat AWs, gate W, merge B responses into one.
  always_comb begin
    wr_state_d      = wr_state_q;
    aw_id_d         = aw_id_q;
    aw_addr_d       = aw_addr_q;
    aw_len_d        = aw_len_q;
    aw_size_d       = aw_size_q;
    aw_burst_d      = aw_burst_q;
    aw_prot_d       = aw_prot_q;
    aw_cnt_d        = aw_cnt_q;
    w_cnt_d         = w_cnt_q;
    b_cnt_d         = b_cnt_q;
    err_d           = err_q;
    master_aw_ready = 1'b0;
    slave_aw_valid  = 1'b0;
    slave_b_ready   = 1'b0;
    master_b_valid  = 1'b0;
    if (slave_w_valid && slave_w_ready) begin
      w_cnt_d = w_cnt_q - 9'd1;
    end
    if ((wr_state_q != WR_IDLE) && (b_cnt_q != 9'd0)) begin
      slave_b_ready = 1'b1;
      if (slave_b_valid) begin
        b_cnt_d = b_cnt_q - 9'd1;
        if ((err_q == RESP_OKAY) && slave_b_resp[1]) begin
          err_d = slave_b_resp;
        end
      end
    end
    case (wr_state_q)
      WR_IDLE: begin
        master_aw_ready = run_q;
        if (run_q && master_aw_valid) begin
          aw_id_d    = master_aw_id;
          aw_addr_d  = master_aw_addr;
          aw_len_d   = master_aw_len;
          aw_size_d  = master_aw_size;
          aw_burst_d = master_aw_burst;
          aw_prot_d  = master_aw_prot;
          aw_cnt_d   = {1'b0, master_aw_len} + 9'd1;
          w_cnt_d    = {1'b0, master_aw_len} + 9'd1;
          b_cnt_d    = {1'b0, master_aw_len} + 9'd1;
          err_d      = RESP_OKAY;
          wr_state_d = WR_ISSUE;
        end
      end
      WR_ISSUE: begin
        slave_aw_valid = (aw_cnt_q != 9'd0);
        if (slave_aw_valid && slave_aw_ready) begin
          aw_addr_d = next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
          aw_cnt_d  = aw_cnt_q - 9'd1;
        end
        if ((aw_cnt_d == 9'd0) && (w_cnt_d == 9'd0)) begin
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        master_b_valid = (b_cnt_q == 9'd0);
        if (master_b_valid && master_b_ready) begin
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // State register; reset discards any burst in flight without a response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state_q  <= RD_IDLE;
      wr_state_q  <= WR_IDLE;
      run_q       <= 1'b0;
      ar_id_q     <= '0;
      ar_addr_q   <= '0;
      ar_len_q    <= '0;
      ar_size_q   <= '0;
      ar_burst_q  <= '0;
      ar_prot_q   <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      aw_id_q     <= '0;
      aw_addr_q   <= '0;
      aw_len_q    <= '0;
      aw_size_q   <= '0;
      aw_burst_q  <= '0;
      aw_prot_q   <= '0;
      aw_cnt_q    <= '0;
      w_cnt_q     <= '0;
      b_cnt_q     <= '0;
      err_q       <= RESP_OKAY;
    end else begin
      rd_state_q  <= rd_state_d;
      wr_state_q  <= wr_state_d;
      run_q       <= run_d;
      ar_id_q     <= ar_id_d;
      ar_addr_q   <= ar_addr_d;
      ar_len_q    <= ar_len_d;
      ar_size_q   <= ar_size_d;
      ar_burst_q  <= ar_burst_d;
      ar_prot_q   <= ar_prot_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      aw_id_q     <= aw_id_d;
      aw_addr_q   <= aw_addr_d;
      aw_len_q    <= aw_len_d;
      aw_size_q   <= aw_size_d;
      aw_burst_q  <= aw_burst_d;
      aw_prot_q   <= aw_prot_d;
      aw_cnt_q    <= aw_cnt_d;
      w_cnt_q     <= w_cnt_d;
      b_cnt_q     <= b_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_to_axi_lite_bridge.sv
// Testbench for axi_to_axi_lite_bridge: directed bursts, an AXI-lite slave
// model downstream, and a scoreboard checked by a separate monitor.
`timescale 1ns/1ps
module tb_axi_to_axi_lite_bridge;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int IW = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [IW-1:0] master_aw_id, master_ar_id, master_b_id, master_r_id;
  logic [AW-1:0] master_aw_addr, master_ar_addr;
  logic [7:0] master_aw_len, master_ar_len;
  logic [2:0] master_aw_size, master_ar_size, master_aw_prot, master_ar_prot;
  logic [1:0] master_aw_burst, master_ar_burst, master_b_resp, master_r_resp;
  logic master_aw_valid, master_aw_ready, master_w_last, master_w_valid, master_w_ready;
  logic master_b_valid, master_b_ready, master_ar_valid, master_ar_ready;
  logic master_r_last, master_r_valid, master_r_ready;
  logic [DW-1:0] master_w_data, master_r_data, slave_w_data, slave_r_data;
  logic [DW/8-1:0] master_w_strb, slave_w_strb;
  logic [AW-1:0] slave_aw_addr, slave_ar_addr;
  logic [2:0] slave_aw_prot, slave_ar_prot;
  logic slave_aw_valid, slave_aw_ready, slave_w_valid, slave_w_ready;
  logic [1:0] slave_b_resp, slave_r_resp;
  logic slave_b_valid, slave_b_ready, slave_ar_valid, slave_ar_ready;
  logic slave_r_valid, slave_r_ready;

  axi_to_axi_lite_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rstn(rstn),
    .master_aw_id(master_aw_id), .master_aw_addr(master_aw_addr), .master_aw_len(master_aw_len),
    .master_aw_size(master_aw_size), .master_aw_burst(master_aw_burst), .master_aw_prot(master_aw_prot),
    .master_aw_valid(master_aw_valid), .master_aw_ready(master_aw_ready),
    .master_w_data(master_w_data), .master_w_strb(master_w_strb), .master_w_last(master_w_last),
    .master_w_valid(master_w_valid), .master_w_ready(master_w_ready),
    .master_b_id(master_b_id), .master_b_resp(master_b_resp), .master_b_valid(master_b_valid),
    .master_b_ready(master_b_ready),
    .master_ar_id(master_ar_id), .master_ar_addr(master_ar_addr), .master_ar_len(master_ar_len),
    .master_ar_size(master_ar_size), .master_ar_burst(master_ar_burst), .master_ar_prot(master_ar_prot),
    .master_ar_valid(master_ar_valid), .master_ar_ready(master_ar_ready),
    .master_r_id(master_r_id), .master_r_data(master_r_data), .master_r_resp(master_r_resp),
    .master_r_last(master_r_last), .master_r_valid(master_r_valid), .master_r_ready(master_r_ready),
    .slave_aw_addr(slave_aw_addr), .slave_aw_prot(slave_aw_prot), .slave_aw_valid(slave_aw_valid),
    .slave_aw_ready(slave_aw_ready),
    .slave_w_data(slave_w_data), .slave_w_strb(slave_w_strb), .slave_w_valid(slave_w_valid),
    .slave_w_ready(slave_w_ready),
    .slave_b_resp(slave_b_resp), .slave_b_valid(slave_b_valid), .slave_b_ready(slave_b_ready),
    .slave_ar_addr(slave_ar_addr), .slave_ar_prot(slave_ar_prot), .slave_ar_valid(slave_ar_valid),
    .slave_ar_ready(slave_ar_ready),
    .slave_r_data(slave_r_data), .slave_r_resp(slave_r_resp), .slave_r_valid(slave_r_valid),
    .slave_r_ready(slave_r_ready)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } r_exp_t;

  int checks = 0;
  int errors = 0;
  int r_seen = 0;

  // Scoreboard queues: {prot, addr} for AR/AW, data for W, {id, resp} for B
  logic [AW+2:0] exp_ar_q[$];
  logic [AW+2:0] exp_aw_q[$];
  logic [DW-1:0] exp_w_q[$];
  logic [IW+1:0] exp_b_q[$];
  r_exp_t        exp_r_q[$];

  // Downstream slave model state
  logic [AW-1:0] rd_pend_q[$];
  logic [1:0]    bresp_script_q[$];
  int aw_seen, w_seen, b_issued;
  logic s_ar_hs, s_r_hs, s_aw_hs, s_w_hs, s_b_hs;
  logic [AW-1:0] s_ar_addr;

  logic [AW+2:0] ar_e, aw_e;
  logic [IW+1:0] b_e;
  r_exp_t        r_e;

  // Read data the slave model returns for a given address
  function automatic logic [DW-1:0] memData(input logic [AW-1:0] addr);
    return {16'hA5A5, addr};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [63:0] actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s: unexpected beat %0h, expected none", name, actual);
  endtask

  // Monitor: compare every handshake against the head of its expected queue
  always @(negedge clk) begin
    if (rstn) begin
      if (slave_ar_valid && slave_ar_ready) begin
        if (exp_ar_q.size() == 0) reportUnexpected("slave_ar", 64'(slave_ar_addr));
        else begin
          ar_e = exp_ar_q.pop_front();
          checkOutput("slave_ar_addr", 64'(slave_ar_addr), 64'(ar_e[AW-1:0]));
          checkOutput("slave_ar_prot", 64'(slave_ar_prot), 64'(ar_e[AW+2:AW]));
        end
      end
      if (slave_aw_valid && slave_aw_ready) begin
        if (exp_aw_q.size() == 0) reportUnexpected("slave_aw", 64'(slave_aw_addr));
        else begin
          aw_e = exp_aw_q.pop_front();
          checkOutput("slave_aw_addr", 64'(slave_aw_addr), 64'(aw_e[AW-1:0]));
          checkOutput("slave_aw_prot", 64'(slave_aw_prot), 64'(aw_e[AW+2:AW]));
        end
      end
      if (slave_w_valid && slave_w_ready) begin
        if (exp_w_q.size() == 0) reportUnexpected("slave_w", slave_w_data);
        else checkOutput("slave_w_data", slave_w_data, exp_w_q.pop_front());
      end
      if (master_r_valid && master_r_ready) begin
        r_seen++;
        if (exp_r_q.size() == 0) reportUnexpected("master_r", master_r_data);
        else begin
          r_e = exp_r_q.pop_front();
          checkOutput("master_r_id", 64'(master_r_id), 64'(r_e.id));
          checkOutput("master_r_data", master_r_data, r_e.data);
          checkOutput("master_r_last", 64'(master_r_last), 64'(r_e.last));
        end
      end
      if (master_b_valid && master_b_ready) begin
        if (exp_b_q.size() == 0) reportUnexpected("master_b", 64'({master_b_id, master_b_resp}));
        else begin
          b_e = exp_b_q.pop_front();
          checkOutput("master_b_id", 64'(master_b_id), 64'(b_e[IW+1:2]));
          checkOutput("master_b_resp", 64'(master_b_resp), 64'(b_e[1:0]));
        end
      end
    end
  end

  // AXI-lite slave model: always-ready AR/AW/W, in-order R and B one per cycle
  initial begin
    slave_aw_ready = 1'b1;
    slave_w_ready  = 1'b1;
    slave_ar_ready = 1'b1;
    slave_r_valid  = 1'b0;
    slave_r_data   = '0;
    slave_r_resp   = 2'b00;
    slave_b_valid  = 1'b0;
    slave_b_resp   = 2'b00;
    aw_seen = 0; w_seen = 0; b_issued = 0;
    forever begin
      @(negedge clk);
      s_ar_hs   = rstn && slave_ar_valid && slave_ar_ready;
      s_ar_addr = slave_ar_addr;
      s_r_hs    = rstn && slave_r_valid && slave_r_ready;
      s_aw_hs   = rstn && slave_aw_valid && slave_aw_ready;
      s_w_hs    = rstn && slave_w_valid && slave_w_ready;
      s_b_hs    = rstn && slave_b_valid && slave_b_ready;
      @(posedge clk);
      #1;
      if (!rstn) begin
        rd_pend_q.delete();
        slave_r_valid = 1'b0;
        slave_b_valid = 1'b0;
        aw_seen = 0; w_seen = 0; b_issued = 0;
      end else begin
        if (s_ar_hs) rd_pend_q.push_back(s_ar_addr);
        if (s_r_hs) slave_r_valid = 1'b0;
        if (!slave_r_valid && rd_pend_q.size() > 0) begin
          slave_r_valid = 1'b1;
          slave_r_data  = memData(rd_pend_q.pop_front());
        end
        if (s_aw_hs) aw_seen++;
        if (s_w_hs) w_seen++;
        if (s_b_hs) slave_b_valid = 1'b0;
        if (!slave_b_valid && (aw_seen > b_issued) && (w_seen > b_issued)) begin
          slave_b_valid = 1'b1;
          slave_b_resp  = (bresp_script_q.size() > 0) ? bresp_script_q.pop_front() : 2'b00;
          b_issued++;
        end
      end
    end
  end

  task automatic sendAr(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [2:0] prot);
    int n;
    bit done;
    @(posedge clk); #1;
    master_ar_id = id; master_ar_addr = addr; master_ar_len = len;
    master_ar_size = 3'd3; master_ar_burst = burst; master_ar_prot = prot;
    master_ar_valid = 1'b1;
    n = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (master_ar_ready) done = 1'b1;
      else if (++n > 200) begin
        reportUnexpected("ar_timeout", 64'(addr));
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
    master_ar_valid = 1'b0;
  endtask

  task automatic sendAw(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [2:0] prot);
    int n;
    bit done;
    @(posedge clk); #1;
    master_aw_id = id; master_aw_addr = addr; master_aw_len = len;
    master_aw_size = 3'd3; master_aw_burst = burst; master_aw_prot = prot;
    master_aw_valid = 1'b1;
    n = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (master_aw_ready) done = 1'b1;
      else if (++n > 200) begin
        reportUnexpected("aw_timeout", 64'(addr));
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
    master_aw_valid = 1'b0;
  endtask

  task automatic sendW(input int beats, input logic [DW-1:0] base);
    int n;
    bit done;
    @(posedge clk); #1;
    for (int i = 0; i < beats; i++) begin
      master_w_data  = base + DW'(i);
      master_w_strb  = '1;
      master_w_last  = (i == beats - 1);
      master_w_valid = 1'b1;
      n = 0; done = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (master_w_ready) done = 1'b1;
        else if (++n > 200) begin
          reportUnexpected("w_timeout", base);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    master_w_valid = 1'b0;
    master_w_last  = 1'b0;
  endtask

  task automatic waitRBeats(input int target);
    int n;
    n = 0;
    while (r_seen < target) begin
      @(negedge clk);
      if (++n > 300) begin
        reportUnexpected("r_wait_timeout", 64'(r_seen));
        return;
      end
    end
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size() + exp_b_q.size() + exp_r_q.size() > 0) begin
      @(negedge clk);
      if (++n > 500) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s_drain: %0d expected beats still pending, expected 0", name,
                 exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size() + exp_b_q.size() + exp_r_q.size());
        return;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pushAr(input logic [AW-1:0] addr, input logic [2:0] prot);
    exp_ar_q.push_back({prot, addr});
  endtask

  task automatic pushR(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic last);
    r_exp_t e;
    e.id = id; e.data = memData(addr); e.last = last;
    exp_r_q.push_back(e);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_m_aw_ready"}, 64'(master_aw_ready), 64'd0);
    checkOutput({tag, "_m_w_ready"},  64'(master_w_ready),  64'd0);
    checkOutput({tag, "_m_ar_ready"}, 64'(master_ar_ready), 64'd0);
    checkOutput({tag, "_m_b_valid"},  64'(master_b_valid),  64'd0);
    checkOutput({tag, "_m_r_valid"},  64'(master_r_valid),  64'd0);
    checkOutput({tag, "_s_aw_valid"}, 64'(slave_aw_valid),  64'd0);
    checkOutput({tag, "_s_w_valid"},  64'(slave_w_valid),   64'd0);
    checkOutput({tag, "_s_ar_valid"}, 64'(slave_ar_valid),  64'd0);
  endtask

  task automatic applyStimulus();
    // Read INCR, id 5
    $display("[TB] read INCR");
    pushAr(48'h100, 3'd2); pushAr(48'h108, 3'd2); pushAr(48'h110, 3'd2); pushAr(48'h118, 3'd2);
    pushR(8'd5, 48'h100, 1'b0); pushR(8'd5, 48'h108, 1'b0);
    pushR(8'd5, 48'h110, 1'b0); pushR(8'd5, 48'h118, 1'b1);
    sendAr(8'd5, 48'h100, 8'd3, 2'b01, 3'd2);
    waitDrain("read_incr");

    // Write WRAP, id 7
    $display("[TB] write WRAP");
    exp_aw_q.push_back({3'd0, 48'h118}); exp_aw_q.push_back({3'd0, 48'h100});
    exp_aw_q.push_back({3'd0, 48'h108}); exp_aw_q.push_back({3'd0, 48'h110});
    for (int i = 0; i < 4; i++) exp_w_q.push_back(64'hC0DE_0000_0000_0000 + 64'(i));
    exp_b_q.push_back({8'd7, 2'b00});
    fork
      sendAw(8'd7, 48'h118, 8'd3, 2'b10, 3'd0);
      sendW(4, 64'hC0DE_0000_0000_0000);
    join
    waitDrain("write_wrap");

    // Write error merge, id 0x22
    $display("[TB] write error merge");
    exp_aw_q.push_back({3'd1, 48'h200}); exp_aw_q.push_back({3'd1, 48'h208});
    exp_aw_q.push_back({3'd1, 48'h210});
    for (int i = 0; i < 3; i++) exp_w_q.push_back(64'h0BAD_0000_0000_0000 + 64'(i));
    bresp_script_q.push_back(2'b00); bresp_script_q.push_back(2'b10); bresp_script_q.push_back(2'b11);
    exp_b_q.push_back({8'h22, 2'b10});
    fork
      sendAw(8'h22, 48'h200, 8'd2, 2'b01, 3'd1);
      sendW(3, 64'h0BAD_0000_0000_0000);
    join
    waitDrain("write_err");

    // Read backpressure, id 9
    $display("[TB] read backpressure");
    for (int i = 0; i < 8; i++) begin
      pushAr(48'h400 + 48'(8 * i), 3'd0);
      pushR(8'd9, 48'h400 + 48'(8 * i), i == 7);
    end
    fork
      sendAr(8'd9, 48'h400, 8'd7, 2'b01, 3'd0);
      begin
        waitRBeats(r_seen + 3);
        @(posedge clk); #1;
        master_r_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checkOutput("slave_r_ready_track", 64'(slave_r_ready), 64'd0);
        end
        @(posedge clk); #1;
        master_r_ready = 1'b1;
        @(negedge clk);
        checkOutput("slave_r_ready_track", 64'(slave_r_ready), 64'd1);
      end
    join
    waitDrain("read_bp");

    // W before AW, id 0x33
    $display("[TB] W before AW");
    exp_aw_q.push_back({3'd5, 48'h300}); exp_aw_q.push_back({3'd5, 48'h308});
    exp_w_q.push_back(64'h5EED_0000_0000_0000); exp_w_q.push_back(64'h5EED_0000_0000_0001);
    exp_b_q.push_back({8'h33, 2'b00});
    fork
      sendW(2, 64'h5EED_0000_0000_0000);
      begin
        repeat (3) @(posedge clk);
        sendAw(8'h33, 48'h300, 8'd1, 2'b01, 3'd5);
      end
    join
    waitDrain("w_before_aw");

    // FIXED read, id 4
    $display("[TB] read FIXED");
    for (int i = 0; i < 8; i++) begin
      pushAr(48'h40, 3'd0);
      pushR(8'd4, 48'h40, i == 7);
    end
    sendAr(8'd4, 48'h40, 8'd7, 2'b00, 3'd0);
    waitDrain("read_fixed");

    // Reset after the 2nd beat of a FIXED burst
    $display("[TB] reset mid-burst");
    for (int i = 0; i < 8; i++) begin
      pushAr(48'h40, 3'd0);
      pushR(8'd6, 48'h40, i == 7);
    end
    sendAr(8'd6, 48'h40, 8'd7, 2'b00, 3'd0);
    waitRBeats(r_seen + 2);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 checkIdleOutputs("midrst");
    exp_ar_q.delete(); exp_r_q.delete();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Misaligned INCR read after reset, id 3
    $display("[TB] read after reset");
    pushAr(48'h504, 3'd0); pushAr(48'h508, 3'd0);
    pushR(8'd3, 48'h504, 1'b0); pushR(8'd3, 48'h508, 1'b1);
    sendAr(8'd3, 48'h504, 8'd1, 2'b01, 3'd0);
    waitDrain("read_post_rst");

    // Back-to-back reads, ids 1 then 2
    $display("[TB] back-to-back reads");
    pushAr(48'h600, 3'd0); pushAr(48'h700, 3'd0); pushAr(48'h708, 3'd0);
    pushR(8'd1, 48'h600, 1'b1); pushR(8'd2, 48'h700, 1'b0); pushR(8'd2, 48'h708, 1'b1);
    sendAr(8'd1, 48'h600, 8'd0, 2'b01, 3'd0);
    sendAr(8'd2, 48'h700, 8'd1, 2'b01, 3'd0);
    waitDrain("b2b");
  endtask

  initial begin
    rstn = 1'b0;
    master_aw_valid = 1'b0; master_w_valid = 1'b0; master_ar_valid = 1'b0;
    master_aw_id = '0; master_aw_addr = '0; master_aw_len = '0; master_aw_size = '0;
    master_aw_burst = '0; master_aw_prot = '0;
    master_ar_id = '0; master_ar_addr = '0; master_ar_len = '0; master_ar_size = '0;
    master_ar_burst = '0; master_ar_prot = '0;
    master_w_data = '0; master_w_strb = '0; master_w_last = 1'b0;
    master_b_ready = 1'b1;
    master_r_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
